iopmp_ctrl_port: RTL and testbench
==================================

Name: iopmp_ctrl_port

Overview:
- TL-UL slave register file holding the IOPMP programming state: hardware config, error config/capture, MDCFG, SRCMD_EN, ENTRYLCK, ENTRY_ADDR/ADDRH/CFG.
- Drives the decoded tables continuously to the IOPMP checker.
- Latches violation records from the checker into the ERR_* registers.
- Single-beat 32-bit accesses, one outstanding transaction.

Parameters:
- IOPMPRegions, 6, number of entries.
- IOPMPMemoryDomains, 3, number of memory domains (MDCFG registers).
- NUM_MASTERS, 3, number of requester IDs (SRCMD_EN registers).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- mst_req_i  in  tl_h2d_t  TL-UL A channel plus d_ready.
- slv_rsp_o  out  tl_d2h_t  TL-UL D channel plus a_ready.
- error_report_i  in  error_registers_t  violation record from checker; valid = err_reqinfo.v.
- error_report_o  out  error_registers_t  current ERR_* register contents.
- entry_conf_table  out  entry_cfg[IOPMPRegions]  per-entry r,w,x,a[1:0].
- entry_addr_table  out  34b[IOPMPRegions]  {ENTRY_ADDRH[1:0], ENTRY_ADDR[31:0]}.
- mdcfg_table  out  16b[IOPMPMemoryDomains]  MDCFG.t.
- srcmd_en_table  out  32b[NUM_MASTERS]  SRCMD_EN (bit0 lock, bits[31:1] MD bitmap).

Behaviour:
- Clocking/reset: one clock (clk). Synchronous, active-low reset. Active-low reset clears all registers, tables, error registers and D-channel outputs to 0; a_ready = 1 after reset.
- Register map (byte offsets, config_pkg):
  - HWCFG0 0x08: bit31 enable, set-only.
  - HWCFG1 0x0C: RO, {IOPMPRegions[15:0], NUM_MASTERS[15:0]}.
  - HWCFG2 0x10: [15:0] prio_entry, RW.
  - ENTRYLCK 0x4C.
  - ERR_CFG 0x60: [7:0] RW.
  - ERR_REQINFO 0x64: bit0 v is W1C, rest RO.
  - ERR_REQADDR 0x68, ERR_REQADDRH 0x6C, ERR_REQID 0x70: all RO.
  - MDCFG 0x800 + 4*m.
  - SRCMD_EN 0x1000 + 32*s.
  - ENTRY_ADDR 0x2000 + 16*i; ENTRY_ADDRH +4; ENTRY_CFG +8 (bits[4:0]).
  - Unimplemented bits read 0.
- Handshake:
  - A beat accepted when a_valid && a_ready.
  - Next cycle: d_valid = 1, a_ready = 0, d_source = a_source, d_size = a_size.
  - Put ops return AccessAck. Get returns AccessAckData with register value.
  - d_valid held until d_ready; a_ready returns high the cycle after the D handshake.
- Writes:
  - PutFullData writes all 4 bytes.
  - PutPartialData writes bytes selected by a_mask[3:0].
  - Register updates in the accept cycle.
- Errors: unmapped offset or index ≥ parameter → no state change; read data 0; d_error = 1.
- Locks:
  - SRCMD_EN[s].bit0 = 1 makes SRCMD_EN[s] read-only until reset.
  - ENTRYLCK bit0 = 1 makes ENTRYLCK read-only. ENTRYLCK[15:1] = f: writes to entry i < f are ignored, with no d_error.
- Error capture:
  - Each cycle error_report_i.err_reqinfo.v = 1 and ERR_REQINFO.v = 0 → load REQINFO/REQADDR/REQADDRH/REQID from error_report_i.
  - While v = 1, new reports are dropped.
  - A SW W1C to v and a capture in the same cycle: the capture wins.
- Tables are combinational views of the registers; an update is visible the cycle after write acceptance.

Decomposition:
- config_pkg: offsets; a_op/d_op encodings.
- iopmp_pkg: entry_cfg struct, error_registers_t.
- top_pkg/tlul_pkg: existing TL types.
- Sub-module iopmp_ctrl_tlul_adapter: A/D handshake, response register, and decode of op/address into wr_en/rd_en/offset/wdata/be. Register file lives in the top.

Test Plan:
- Write HWCFG1 0x12345678, then Get HWCFG1 → 0x00060003; Get HWCFG0 after Put 0xFFFF0000 → bit31 = 1.
- Put MDCFG0/1/2 = 2/4/6 and SRCMD_EN0/1/2 = 0x6/0x1/0x4 → mdcfg_table = {2,4,6}, srcmd_en_table = {6,1,4}. Then Put SRCMD_EN1 = 0x8 → unchanged (locked).
- Put ENTRY_ADDR0..5 = 0x20000000, 0x40000070, 0x50000000, 0x70000000, 0x80000000, 0x90000000 → entry_addr_table matches with bits[33:32] = 0. Put ENTRY_CFG0..4 = 0x19 → entries r = 1, a = 3; entry 5 stays 0. Get ENTRY_CFG3 → 0x19.
- Put ENTRYLCK = 0x4 (f = 2), then Put ENTRY_CFG1 = 0x1F → still 0x19, d_error = 0; Put ENTRY_CFG2 = 0x1F → applied.
- Drive error_report_i v = 1, addr 0x1234 for one cycle → ERR_REQINFO.v = 1, ERR_REQADDR = 0x1234. Second report with addr 0x5678 → ignored. Put ERR_REQINFO = 1 → v cleared.
- Hold d_ready = 0 for 3 cycles after a Get → d_valid stays high, data stable, a_ready = 0. Get at 0x3FFC → d_error = 1, data 0.

Source files
------------

// File: rtl/iopmp_ctrl_port_pkg.sv
// Shared types for the IOPMP control port: TL-UL channel structs, opcode encodings,
// register offsets, decoded table entry format and the violation record layout.
package iopmp_ctrl_port_pkg;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'h0,
        PUT_PARTIAL_DATA = 3'h1,
        GET              = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'h0,
        ACCESS_ACK_DATA = 3'h1
    } tl_d_op_e;

    localparam logic [15:0] HWCFG0_OFFSET       = 16'h0008;
    localparam logic [15:0] HWCFG1_OFFSET       = 16'h000C;
    localparam logic [15:0] HWCFG2_OFFSET       = 16'h0010;
    localparam logic [15:0] ENTRYLCK_OFFSET     = 16'h004C;
    localparam logic [15:0] ERR_CFG_OFFSET      = 16'h0060;
    localparam logic [15:0] ERR_REQINFO_OFFSET  = 16'h0064;
    localparam logic [15:0] ERR_REQADDR_OFFSET  = 16'h0068;
    localparam logic [15:0] ERR_REQADDRH_OFFSET = 16'h006C;
    localparam logic [15:0] ERR_REQID_OFFSET    = 16'h0070;
    localparam logic [15:0] MDCFG_BASE          = 16'h0800;
    localparam logic [15:0] SRCMD_EN_BASE       = 16'h1000;
    localparam logic [15:0] ENTRY_BASE          = 16'h2000;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } entry_cfg_t;

    typedef struct packed {
        logic [30:0] info;
        logic        v;
    } err_reqinfo_t;

    typedef struct packed {
        err_reqinfo_t err_reqinfo;
        logic [31:0]  err_reqaddr;
        logic [31:0]  err_reqaddrh;
        logic [31:0]  err_reqid;
    } error_registers_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iopmp_ctrl_tlul_adapter.sv
// TL-UL single-outstanding slave front end: accepts one A beat, decodes it into a
// register-file strobe, and holds the D response until the host takes it.
module iopmp_ctrl_tlul_adapter
    import iopmp_ctrl_port_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic        wr_en,
    output logic [15:0] offset,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    input  logic [31:0] rdata,
    input  logic        addr_err
);

    logic        a_ready_reg;
    logic        d_valid_reg;
    logic        d_error_reg;
    logic [2:0]  d_opcode_reg;
    logic [1:0]  d_size_reg;
    logic [7:0]  d_source_reg;
    logic [31:0] d_data_reg;

    logic accept;
    logic is_put;
    logic is_get;
    logic rd_en;
    logic range_err;
    logic resp_err;
    logic unused_bits;

    assign accept    = tl_i.a_valid && a_ready_reg;
    assign is_put    = (tl_i.a_opcode == PUT_FULL_DATA) || (tl_i.a_opcode == PUT_PARTIAL_DATA);
    assign is_get    = (tl_i.a_opcode == GET);
    // The register space is 64 KiB; anything above must not alias onto it.
    assign range_err = |tl_i.a_address[31:16];
    assign resp_err  = range_err || addr_err || !(is_put || is_get);

    assign wr_en  = accept && is_put && !range_err;
    assign rd_en  = accept && is_get;
    assign offset = {tl_i.a_address[15:2], 2'b00};
    assign wdata  = tl_i.a_data;
    assign be     = (tl_i.a_opcode == PUT_FULL_DATA) ? 4'hF : tl_i.a_mask;

    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_ready_reg  <= 1'b1;
            d_valid_reg  <= 1'b0;
            d_error_reg  <= 1'b0;
            d_opcode_reg <= '0;
            d_size_reg   <= '0;
            d_source_reg <= '0;
            d_data_reg   <= '0;
        end else if (accept) begin
            a_ready_reg  <= 1'b0;
            d_valid_reg  <= 1'b1;
            d_opcode_reg <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size_reg   <= tl_i.a_size;
            d_source_reg <= tl_i.a_source;
            d_error_reg  <= resp_err;
            d_data_reg   <= (rd_en && !resp_err) ? rdata : '0;
        end else if (d_valid_reg && tl_i.d_ready) begin
            d_valid_reg <= 1'b0;
            a_ready_reg <= 1'b1;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_reg;
        tl_o.d_opcode = d_opcode_reg;
        tl_o.d_size   = d_size_reg;
        tl_o.d_source = d_source_reg;
        tl_o.d_data   = d_data_reg;
        tl_o.d_error  = d_error_reg;
        tl_o.a_ready  = a_ready_reg;
    end

endmodule

// File: rtl/iopmp_ctrl_port.sv
// IOPMP programming register file behind a TL-UL slave port; exposes the decoded
// entry/MD/SRCMD tables to the checker and captures its violation records.
module iopmp_ctrl_port
    import iopmp_ctrl_port_pkg::*;
#(
    parameter int IOPMPRegions       = 6,
    parameter int IOPMPMemoryDomains = 3,
    parameter int NUM_MASTERS        = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  tl_h2d_t                                mst_req_i,
    output tl_d2h_t                                slv_rsp_o,
    input  error_registers_t                       error_report_i,
    output error_registers_t                       error_report_o,
    output entry_cfg_t [IOPMPRegions-1:0]          entry_conf_table,
    output logic [IOPMPRegions-1:0][33:0]          entry_addr_table,
    output logic [IOPMPMemoryDomains-1:0][15:0]    mdcfg_table,
    output logic [NUM_MASTERS-1:0][31:0]           srcmd_en_table
);

    logic        wr_en;
    logic [15:0] offset;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [31:0] wval;
    logic        hit;
    logic        addr_err;

    logic             hwcfg0_en_reg;
    logic [15:0]      hwcfg2_reg;
    logic [15:0]      entrylck_reg;
    logic [7:0]       err_cfg_reg;
    error_registers_t err_reg;

    logic [15:0] mdcfg_reg     [IOPMPMemoryDomains];
    logic [31:0] srcmd_en_reg  [NUM_MASTERS];
    logic [31:0] entry_addr_reg[IOPMPRegions];
    logic [1:0]  entry_addrh_reg[IOPMPRegions];
    entry_cfg_t  entry_cfg_reg [IOPMPRegions];

    logic [IOPMPMemoryDomains-1:0] mdcfg_sel;
    logic [NUM_MASTERS-1:0]        srcmd_sel;
    logic [IOPMPRegions-1:0]       eaddr_sel;
    logic [IOPMPRegions-1:0]       eaddrh_sel;
    logic [IOPMPRegions-1:0]       ecfg_sel;
    logic [IOPMPRegions-1:0]       entry_wr_ok;

    iopmp_ctrl_tlul_adapter u_adapter (
        .clk      (clk),
        .reset    (reset),
        .tl_i     (mst_req_i),
        .tl_o     (slv_rsp_o),
        .wr_en    (wr_en),
        .offset   (offset),
        .wdata    (wdata),
        .be       (be),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    // Byte-merge against the current readback so every register shares one merge path.
    assign wval = apply_be(rdata, wdata, be);

    for (genvar gi = 0; gi < IOPMPMemoryDomains; gi++) begin : g_mdcfg
        assign mdcfg_sel[gi]   = (offset == 16'(MDCFG_BASE + 4*gi));
        assign mdcfg_table[gi] = mdcfg_reg[gi];
        always_ff @(posedge clk) begin
            if (!reset) begin
                mdcfg_reg[gi] <= '0;
            end else if (wr_en && mdcfg_sel[gi]) begin
                mdcfg_reg[gi] <= wval[15:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_srcmd
        assign srcmd_sel[gi]      = (offset == 16'(SRCMD_EN_BASE + 32*gi));
        assign srcmd_en_table[gi] = srcmd_en_reg[gi];
        always_ff @(posedge clk) begin
            if (!reset) begin
                srcmd_en_reg[gi] <= '0;
            end else if (wr_en && srcmd_sel[gi] && !srcmd_en_reg[gi][0]) begin
                srcmd_en_reg[gi] <= wval;
            end
        end
    end

    for (genvar gi = 0; gi < IOPMPRegions; gi++) begin : g_entry
        assign eaddr_sel[gi]  = (offset == 16'(ENTRY_BASE + 16*gi));
        assign eaddrh_sel[gi] = (offset == 16'(ENTRY_BASE + 16*gi + 4));
        assign ecfg_sel[gi]   = (offset == 16'(ENTRY_BASE + 16*gi + 8));
        // Entries below the ENTRYLCK boundary silently ignore writes.
        assign entry_wr_ok[gi] = wr_en && (15'(gi) >= entrylck_reg[15:1]);

        assign entry_conf_table[gi] = entry_cfg_reg[gi];
        assign entry_addr_table[gi] = {entry_addrh_reg[gi], entry_addr_reg[gi]};

        always_ff @(posedge clk) begin
            if (!reset) begin
                entry_addr_reg[gi]  <= '0;
                entry_addrh_reg[gi] <= '0;
                entry_cfg_reg[gi]   <= '0;
            end else if (entry_wr_ok[gi]) begin
                if (eaddr_sel[gi])  entry_addr_reg[gi]  <= wval;
                if (eaddrh_sel[gi]) entry_addrh_reg[gi] <= wval[1:0];
                if (ecfg_sel[gi])   entry_cfg_reg[gi]   <= entry_cfg_t'(wval[4:0]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (offset)
            HWCFG0_OFFSET:       rdata = {hwcfg0_en_reg, 31'b0};
            HWCFG1_OFFSET:       rdata = {16'(IOPMPRegions), 16'(NUM_MASTERS)};
            HWCFG2_OFFSET:       rdata = {16'b0, hwcfg2_reg};
            ENTRYLCK_OFFSET:     rdata = {16'b0, entrylck_reg};
            ERR_CFG_OFFSET:      rdata = {24'b0, err_cfg_reg};
            ERR_REQINFO_OFFSET:  rdata = err_reg.err_reqinfo;
            ERR_REQADDR_OFFSET:  rdata = err_reg.err_reqaddr;
            ERR_REQADDRH_OFFSET: rdata = err_reg.err_reqaddrh;
            ERR_REQID_OFFSET:    rdata = err_reg.err_reqid;
            default:             hit   = 1'b0;
        endcase
        for (int m = 0; m < IOPMPMemoryDomains; m++) begin
            if (mdcfg_sel[m]) begin
                hit   = 1'b1;
                rdata = {16'b0, mdcfg_reg[m]};
            end
        end
        for (int s = 0; s < NUM_MASTERS; s++) begin
            if (srcmd_sel[s]) begin
                hit   = 1'b1;
                rdata = srcmd_en_reg[s];
            end
        end
        for (int i = 0; i < IOPMPRegions; i++) begin
            if (eaddr_sel[i]) begin
                hit   = 1'b1;
                rdata = entry_addr_reg[i];
            end
            if (eaddrh_sel[i]) begin
                hit   = 1'b1;
                rdata = {30'b0, entry_addrh_reg[i]};
            end
            if (ecfg_sel[i]) begin
                hit   = 1'b1;
                rdata = {27'b0, entry_cfg_reg[i]};
            end
        end
    end

    assign addr_err       = !hit;
    assign error_report_o = err_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hwcfg0_en_reg <= 1'b0;
            hwcfg2_reg    <= '0;
            entrylck_reg  <= '0;
            err_cfg_reg   <= '0;
            err_reg       <= '0;
        end else begin
            if (wr_en && (offset == HWCFG0_OFFSET) && be[3] && wdata[31]) begin
                hwcfg0_en_reg <= 1'b1;
            end
            if (wr_en && (offset == HWCFG2_OFFSET)) begin
                hwcfg2_reg <= wval[15:0];
            end
            if (wr_en && (offset == ENTRYLCK_OFFSET) && !entrylck_reg[0]) begin
                entrylck_reg <= wval[15:0];
            end
            if (wr_en && (offset == ERR_CFG_OFFSET)) begin
                err_cfg_reg <= wval[7:0];
            end
            // A fresh capture takes priority over a software clear of v.
            if (error_report_i.err_reqinfo.v && !err_reg.err_reqinfo.v) begin
                err_reg <= error_report_i;
            end else if (wr_en && (offset == ERR_REQINFO_OFFSET) && be[0] && wdata[0]) begin
                err_reg.err_reqinfo.v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iopmp_ctrl_port.sv
// Bench for iopmp_ctrl_port: directed scenarios followed by random TL-UL traffic,
// all responses and tables compared against a register-map model.
module tb_iopmp_ctrl_port;
    import iopmp_ctrl_port_pkg::*;

    localparam int R  = 6;
    localparam int MD = 3;
    localparam int NM = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    tl_h2d_t          req;
    tl_d2h_t          rsp;
    error_registers_t err_in;
    error_registers_t err_out;
    entry_cfg_t [R-1:0]     conf_t;
    logic [R-1:0][33:0]     addr_t;
    logic [MD-1:0][15:0]    md_t;
    logic [NM-1:0][31:0]    src_t;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    // Reference model state
    bit        m_en;
    bit [15:0] m_prio;
    bit [15:0] m_lck;
    bit [7:0]  m_errcfg;
    bit [31:0] m_info, m_eaddr, m_eaddrh, m_eid;
    bit [15:0] m_md [MD];
    bit [31:0] m_src[NM];
    bit [31:0] m_ea [R];
    bit [1:0]  m_eah[R];
    bit [4:0]  m_ec [R];

    always #5 clk = ~clk;

    iopmp_ctrl_port #(
        .IOPMPRegions       (R),
        .IOPMPMemoryDomains (MD),
        .NUM_MASTERS        (NM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mst_req_i        (req),
        .slv_rsp_o        (rsp),
        .error_report_i   (err_in),
        .error_report_o   (err_out),
        .entry_conf_table (conf_t),
        .entry_addr_table (addr_t),
        .mdcfg_table      (md_t),
        .srcmd_en_table   (src_t)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 for an unmapped offset; d gets the architectural read value.
    function automatic bit m_read(input int unsigned a, output logic [31:0] d);
        d = '0;
        if (a == 'h08)      d = {m_en, 31'b0};
        else if (a == 'h0C) d = {16'(R), 16'(NM)};
        else if (a == 'h10) d = {16'b0, m_prio};
        else if (a == 'h4C) d = {16'b0, m_lck};
        else if (a == 'h60) d = {24'b0, m_errcfg};
        else if (a == 'h64) d = m_info;
        else if (a == 'h68) d = m_eaddr;
        else if (a == 'h6C) d = m_eaddrh;
        else if (a == 'h70) d = m_eid;
        else if (a >= 'h800 && a < 'h800 + 4*MD && a % 4 == 0)
            d = {16'b0, m_md[(a - 'h800) / 4]};
        else if (a >= 'h1000 && a < 'h1000 + 32*NM && a % 32 == 0)
            d = m_src[(a - 'h1000) / 32];
        else if (a >= 'h2000 && a < 'h2000 + 16*R && a % 16 < 12) begin
            case (a % 16)
                0:       d = m_ea[(a - 'h2000) / 16];
                4:       d = {30'b0, m_eah[(a - 'h2000) / 16]};
                default: d = {27'b0, m_ec[(a - 'h2000) / 16]};
            endcase
        end else
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_write(input int unsigned a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] cur;
        logic [31:0] nv;
        int unsigned idx;
        if (m_read(a, cur)) return;
        for (int b = 0; b < 4; b++) nv[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        if (a == 'h08) begin
            if (be[3] && wd[31]) m_en = 1'b1;
        end else if (a == 'h10) m_prio = nv[15:0];
        else if (a == 'h4C) begin
            if (!m_lck[0]) m_lck = nv[15:0];
        end else if (a == 'h60) m_errcfg = nv[7:0];
        else if (a == 'h64) begin
            if (be[0] && wd[0]) m_info[0] = 1'b0;
        end else if (a >= 'h800 && a < 'h1000) m_md[(a - 'h800) / 4] = nv[15:0];
        else if (a >= 'h1000 && a < 'h2000) begin
            idx = (a - 'h1000) / 32;
            if (!m_src[idx][0]) m_src[idx] = nv;
        end else if (a >= 'h2000) begin
            idx = (a - 'h2000) / 16;
            if (idx >= m_lck[15:1]) begin
                case (a % 16)
                    0:       m_ea[idx]  = nv;
                    4:       m_eah[idx] = nv[1:0];
                    default: m_ec[idx]  = nv[4:0];
                endcase
            end
        end
    endfunction

    task automatic check_tables();
        logic [R*5-1:0]   ec;
        logic [R*34-1:0]  ea;
        logic [MD*16-1:0] md;
        logic [NM*32-1:0] sr;
        for (int i = 0; i < R; i++) begin
            ec[5*i +: 5]   = m_ec[i];
            ea[34*i +: 34] = {m_eah[i], m_ea[i]};
        end
        for (int i = 0; i < MD; i++) md[16*i +: 16] = m_md[i];
        for (int i = 0; i < NM; i++) sr[32*i +: 32] = m_src[i];
        check_val("entry_conf_table", 256'(conf_t), 256'(ec));
        check_val("entry_addr_table", 256'(addr_t), 256'(ea));
        check_val("mdcfg_table", 256'(md_t), 256'(md));
        check_val("srcmd_en_table", 256'(src_t), 256'(sr));
        check_val("error_report_o", 256'(err_out), 256'({m_info, m_eaddr, m_eaddrh, m_eid}));
    endtask

    task automatic tl_access(input logic [2:0] op, input int unsigned addr, input logic [31:0] data,
                             input logic [3:0] mask, input int stall,
                             output logic [31:0] rd, output logic rerr);
        logic [31:0] exp_d;
        bit          exp_e;
        logic [7:0]  src;
        logic [1:0]  sz;
        int          cnt;
        src = 8'($urandom);
        sz  = 2'($urandom);
        @(negedge clk);
        req.a_valid   = 1'b1;
        req.a_opcode  = op;
        req.a_param   = '0;
        req.a_size    = sz;
        req.a_source  = src;
        req.a_address = addr;
        req.a_mask    = mask;
        req.a_data    = data;
        req.d_ready   = 1'b0;
        cnt = 0;
        while (!rsp.a_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_val("a_ready_wait", 256'(rsp.a_ready), 256'(1));
        exp_e = m_read(addr, exp_d);
        if (op != GET) exp_d = '0;
        @(posedge clk);
        if (op == PUT_FULL_DATA)         m_write(addr, data, 4'hF);
        else if (op == PUT_PARTIAL_DATA) m_write(addr, data, mask);
        @(negedge clk);
        req.a_valid = 1'b0;
        check_val("d_valid_rise", 256'(rsp.d_valid), 256'(1));
        check_val("a_ready_busy", 256'(rsp.a_ready), 256'(0));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_val("stall_d_valid", 256'(rsp.d_valid), 256'(1));
            check_val("stall_a_ready", 256'(rsp.a_ready), 256'(0));
            check_val("stall_d_data", 256'(rsp.d_data), 256'(exp_d));
        end
        req.d_ready = 1'b1;
        check_val("d_data", 256'(rsp.d_data), 256'(exp_d));
        check_val("d_error", 256'(rsp.d_error), 256'(exp_e));
        check_val("d_opcode", 256'(rsp.d_opcode), 256'((op == GET) ? 3'd1 : 3'd0));
        check_val("d_source", 256'(rsp.d_source), 256'(src));
        check_val("d_size", 256'(rsp.d_size), 256'(sz));
        rd   = rsp.d_data;
        rerr = rsp.d_error;
        @(negedge clk);
        req.d_ready = 1'b0;
        check_val("d_valid_fall", 256'(rsp.d_valid), 256'(0));
        check_val("a_ready_back", 256'(rsp.a_ready), 256'(1));
        check_tables();
        txn_no++;
        $display("txn %0d op=%0d addr=%h wdata=%h mask=%h rdata=%h err=%0d",
                 txn_no, op, addr, data, mask, rd, rerr);
    endtask

    task automatic inject_err(input logic [31:0] addr);
        @(negedge clk);
        err_in = '0;
        err_in.err_reqinfo.info = 31'($urandom);
        err_in.err_reqinfo.v    = 1'b1;
        err_in.err_reqaddr      = addr;
        err_in.err_reqaddrh     = $urandom;
        err_in.err_reqid        = $urandom;
        @(posedge clk);
        if (!m_info[0]) begin
            m_info   = err_in.err_reqinfo;
            m_eaddr  = err_in.err_reqaddr;
            m_eaddrh = err_in.err_reqaddrh;
            m_eid    = err_in.err_reqid;
        end
        @(negedge clk);
        err_in = '0;
        check_tables();
    endtask

    function automatic int unsigned rand_addr();
        int unsigned fixed[11] = '{'h08, 'h0C, 'h10, 'h4C, 'h60, 'h64, 'h68, 'h6C, 'h70, 'h00, 'h14};
        case ($urandom_range(0, 5))
            0:       return fixed[$urandom_range(0, 10)];
            1:       return 'h800 + 4 * $urandom_range(0, MD);
            2:       return 'h1000 + 32 * $urandom_range(0, NM) + (($urandom_range(0, 3) == 0) ? 4 : 0);
            3, 4:    return 'h2000 + 16 * $urandom_range(0, R) + 4 * $urandom_range(0, 3);
            default: return 4 * $urandom_range(0, 'hFFF);
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic        re;
        int unsigned eaddrs[6] = '{'h20000000, 'h40000070, 'h50000000, 'h70000000, 'h80000000, 'h90000000};

        req    = '0;
        err_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_a_ready", 256'(rsp.a_ready), 256'(1));
        check_val("rst_d_valid", 256'(rsp.d_valid), 256'(0));
        check_val("rst_d_data", 256'(rsp.d_data), 256'(0));
        check_val("rst_d_error", 256'(rsp.d_error), 256'(0));
        check_tables();
        reset = 1'b1;

        // HWCFG registers
        tl_access(PUT_FULL_DATA, 'h0C, 32'h12345678, 4'hF, 0, rd, re);
        tl_access(GET, 'h0C, 32'h0, 4'hF, 0, rd, re);
        check_val("hwcfg1_ro", 256'(rd), 256'(32'h00060003));
        tl_access(PUT_FULL_DATA, 'h08, 32'hFFFF0000, 4'hF, 0, rd, re);
        tl_access(GET, 'h08, 32'h0, 4'hF, 0, rd, re);
        check_val("hwcfg0_enable", 256'(rd[31]), 256'(1));

        // MDCFG / SRCMD_EN and lock
        for (int m = 0; m < MD; m++) tl_access(PUT_FULL_DATA, 'h800 + 4*m, 2*(m+1), 4'hF, 0, rd, re);
        tl_access(PUT_FULL_DATA, 'h1000, 32'h6, 4'hF, 0, rd, re);
        tl_access(PUT_FULL_DATA, 'h1020, 32'h1, 4'hF, 0, rd, re);
        tl_access(PUT_FULL_DATA, 'h1040, 32'h4, 4'hF, 0, rd, re);
        check_val("mdcfg_plan", 256'(md_t), 256'({16'd6, 16'd4, 16'd2}));
        check_val("srcmd_plan", 256'(src_t), 256'({32'd4, 32'd1, 32'd6}));
        tl_access(PUT_FULL_DATA, 'h1020, 32'h8, 4'hF, 0, rd, re);
        check_val("srcmd_locked", 256'(src_t[1]), 256'(32'h1));

        // Entries
        for (int i = 0; i < R; i++) tl_access(PUT_FULL_DATA, 'h2000 + 16*i, eaddrs[i], 4'hF, 0, rd, re);
        check_val("entry_addr1", 256'(addr_t[1]), 256'(34'h040000070));
        for (int i = 0; i < 5; i++) tl_access(PUT_FULL_DATA, 'h2008 + 16*i, 32'h19, 4'hF, 0, rd, re);
        check_val("entry5_cfg_zero", 256'(conf_t[5]), 256'(0));
        tl_access(GET, 'h2038, 32'h0, 4'hF, 0, rd, re);
        check_val("entry3_cfg", 256'(rd), 256'(32'h19));

        // ENTRYLCK boundary f = 2
        tl_access(PUT_FULL_DATA, 'h4C, 32'h4, 4'hF, 0, rd, re);
        tl_access(PUT_FULL_DATA, 'h2018, 32'h1F, 4'hF, 0, rd, re);
        check_val("locked_entry_noerr", 256'(re), 256'(0));
        check_val("locked_entry_cfg", 256'(conf_t[1]), 256'(5'h19));
        tl_access(PUT_FULL_DATA, 'h2028, 32'h1F, 4'hF, 0, rd, re);
        check_val("unlocked_entry_cfg", 256'(conf_t[2]), 256'(5'h1F));

        // Error capture, drop while valid, W1C
        inject_err(32'h1234);
        tl_access(GET, 'h68, 32'h0, 4'hF, 0, rd, re);
        check_val("err_addr_first", 256'(rd), 256'(32'h1234));
        inject_err(32'h5678);
        tl_access(GET, 'h68, 32'h0, 4'hF, 0, rd, re);
        check_val("err_addr_kept", 256'(rd), 256'(32'h1234));
        tl_access(PUT_FULL_DATA, 'h64, 32'h1, 4'hF, 0, rd, re);
        check_val("err_v_cleared", 256'(err_out.err_reqinfo.v), 256'(0));

        // D-channel backpressure and unmapped access
        tl_access(GET, 'h2008, 32'h0, 4'hF, 3, rd, re);
        tl_access(GET, 'h3FFC, 32'h0, 4'hF, 0, rd, re);
        check_val("unmapped_err", 256'(re), 256'(1));
        check_val("unmapped_data", 256'(rd), 256'(0));

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            logic [2:0] op;
            case ($urandom_range(0, 2))
                0:       op = PUT_FULL_DATA;
                1:       op = PUT_PARTIAL_DATA;
                default: op = GET;
            endcase
            if ($urandom_range(0, 9) == 0) inject_err($urandom);
            tl_access(op, rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), rd, re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
